seq_scan_ctrl: RTL and testbench

//  Scheduling controller for the serial "0101" sequence detector (clk, reset, x -> y).

---
 rtl/seq_scan_pkg.sv | 12 +
 rtl/seq_detect_0101.sv | 33 +++
 rtl/seq_scan_ctrl.sv | 88 ++++++++
 tb/tb_seq_scan_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared encodings for the "0101" scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [3:0] PATTERN = 4'b0101;

endpackage

// File: rtl/seq_detect_0101.sv
// Mealy overlapping "0101" detector.
//   clk, reset (async, active-high), clr (sync clear), x (serial bit), y (match on this bit)
module seq_detect_0101
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic x,
  output logic y
);

  logic [2:0] hist;
  logic [1:0] seen;

  // Three-bit history plus a saturating fill count; the fill count keeps the
  // cleared zeros from posing as real leading bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      seen <= '0;
    end else if (clr) begin
      hist <= '0;
      seen <= '0;
    end else begin
      hist <= {hist[1:0], x};
      if (seen != 2'd3) seen <= seen + 2'd1;
    end
  end

  assign y = (seen == 2'd3) && ({hist, x} == PATTERN);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller around the "0101" detector.
//   start/data_in in; busy, done (pulse), found, match_count, first_pos out.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  parameter int POS_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] match_count,
  output logic [POS_W-1:0] first_pos
);

  localparam logic [POS_W-1:0] LAST = POS_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [POS_W-1:0] bit_idx;
  logic             det_clr;
  logic             det_y;

  assign det_clr = (state == IDLE) && start;

  seq_detect_0101 u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .x     (shreg[WIDTH-1]),
    .y     (det_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      match_count <= '0;
      first_pos   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg       <= data_in;
            bit_idx     <= '0;
            match_count <= '0;
            found       <= 1'b0;
            first_pos   <= '0;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_idx <= bit_idx + POS_W'(1);
          if (det_y) begin
            match_count <= match_count + CNT_W'(1);
            if (!found) begin
              found     <= 1'b1;
              first_pos <= bit_idx;
            end
          end
          if (bit_idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic [4:0]    match_count;
  logic [3:0]    first_pos;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WIDTH(16), .CNT_W(5), .POS_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .match_count (match_count),
    .first_pos   (first_pos)
  );

  // Reference: slide a 4-bit window over the word MSB-first; window ending at
  // index i covers bit indices i-3..i (index 0 = MSB).
  function automatic void model(input logic [W-1:0] w, output int cnt, output int pos);
    logic [W-1:0] s;
    cnt = 0;
    pos = 0;
    for (int i = 3; i < W; i++) begin
      s = w >> (W - 1 - i);
      if (s[3:0] == 4'b0101) begin
        if (cnt == 0) pos = i;
        cnt++;
      end
    end
  endfunction

  // Full scan with latency checks; data_in is scrambled while busy, and
  // junk asserts start once while busy and during the done cycle.
  task automatic do_scan(input logic [W-1:0] w, input string name, input bit junk);
    int cnt, pos;
    model(w, cnt, pos);
    @(negedge clk);
    data_in = w;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errs++;
        $display("FAIL %s busy_cycle%0d: busy=%b done=%b, need busy=1 done=0", name, k, busy, done);
      end
      data_in = W'($urandom);
      start = (junk && k == 5);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s done_pulse: done=%b busy=%b, need done=1 busy=0", name, done, busy);
    end
    vectors++;
    if (match_count !== 5'(cnt) || found !== (cnt != 0) || first_pos !== 4'(pos)) begin
      errs++;
      $display("FAIL %s result(w=%h): count=%0d found=%b pos=%0d, need count=%0d found=%b pos=%0d",
               name, w, match_count, found, first_pos, cnt, cnt != 0, pos);
    end
    start = junk;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s after_done: done=%b busy=%b, need 0 0", name, done, busy);
    end
    if (junk) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || match_count !== 5'(cnt) || first_pos !== 4'(pos)) begin
        errs++;
        $display("FAIL %s ignored_start: busy=%b count=%0d pos=%0d, need busy=0 count=%0d pos=%0d",
                 name, busy, match_count, first_pos, cnt, pos);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, found, match_count, first_pos} !== '0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b found=%b count=%0d pos=%0d, need all 0",
               busy, done, found, match_count, first_pos);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL idle_no_start: busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    do_scan(16'h5555, "alt5555", 1'b0);
    do_scan(16'h0000, "zeros", 1'b0);
    do_scan(16'hFFF5, "lsb_match", 1'b0);
    do_scan(16'h5A5A, "mixed", 1'b0);
  endtask

  task automatic test_ignored_start();
    do_scan(16'h5000, "busy_start", 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    data_in = 16'h5555;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, found, match_count, first_pos} !== '0) begin
      errs++;
      $display("FAIL midscan_reset: busy=%b done=%b found=%b count=%0d pos=%0d, need all 0",
               busy, done, found, match_count, first_pos);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL no_done_after_reset c%0d: done=%b busy=%b, need 0 0", k, done, busy);
      end
    end
    do_scan(16'h5000, "post_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    do_scan(16'h0005, "b2b_first", 1'b0);
    do_scan(16'hA000, "b2b_second", 1'b0);
    do_scan(16'h0A05, "b2b_third", 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_scan(W'($urandom), "random", ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
